// File: rtl/heap_ram.sv
// Bump-allocated word heap with zero-sweep on reset and clear.
// Ports: clk/rst, req_* (valid/ready request), rsp_* (valid/ready response), used, full.
module heap_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [ADDR_W:0]   req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W:0]   used,
  output logic              full
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_U = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W+1:0] DEPTH_W = {2'b01, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    SWEEP,
    IDLE,
    RESP
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic              from_clr, from_clr_nx;
  logic [ADDR_W:0]   used_nx;
  logic              rsp_valid_nx;
  logic [DATA_W-1:0] rsp_data_nx;
  logic              rsp_err_nx;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              in_range;
  logic              alloc_ok;
  logic              last;
  logic              wr_en;
  logic [ADDR_W+1:0] sum;
  logic              op_rd, op_wr, op_al, op_cl;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign full      = (used == DEPTH_U);

  assign op_rd = (req_op == 2'b00);
  assign op_wr = (req_op == 2'b01);
  assign op_al = (req_op == 2'b10);
  assign op_cl = (req_op == 2'b11);

  assign in_range = ({1'b0, req_addr} < used);
  // Extra top bit keeps used + len from wrapping.
  assign sum      = {1'b0, used} + {1'b0, req_len};
  assign alloc_ok = (req_len != '0) && (sum <= DEPTH_W);
  assign last     = (cnt == {ADDR_W{1'b1}});
  assign wr_en    = accept && op_wr && in_range;

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    from_clr_nx  = from_clr;
    used_nx      = used;
    rsp_valid_nx = rsp_valid;
    rsp_data_nx  = rsp_data;
    rsp_err_nx   = rsp_err;
    unique case (state)
      SWEEP: begin
        cnt_nx = cnt + 1'b1;
        if (last) begin
          from_clr_nx = 1'b0;
          if (from_clr) begin
            // Clear answers only once every word is zero.
            state_nx     = RESP;
            rsp_valid_nx = 1'b1;
            rsp_data_nx  = '0;
            rsp_err_nx   = 1'b0;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      IDLE: begin
        if (accept) begin
          state_nx     = RESP;
          rsp_valid_nx = 1'b1;
          rsp_data_nx  = '0;
          rsp_err_nx   = 1'b0;
          unique case (1'b1)
            op_rd: begin
              if (in_range) rsp_data_nx = mem[req_addr];
              else          rsp_err_nx  = 1'b1;
            end
            op_wr: begin
              if (!in_range) rsp_err_nx = 1'b1;
            end
            op_al: begin
              if (alloc_ok) begin
                rsp_data_nx = DATA_W'(used);
                used_nx     = sum[ADDR_W:0];
              end else begin
                rsp_err_nx = 1'b1;
              end
            end
            op_cl: begin
              state_nx     = SWEEP;
              cnt_nx       = '0;
              from_clr_nx  = 1'b1;
              used_nx      = '0;
              rsp_valid_nx = 1'b0;
            end
          endcase
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nx     = IDLE;
          rsp_valid_nx = 1'b0;
          rsp_data_nx  = '0;
          rsp_err_nx   = 1'b0;
        end
      end
      default: begin
        state_nx = SWEEP;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SWEEP;
      cnt       <= '0;
      from_clr  <= 1'b0;
      used      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      from_clr  <= from_clr_nx;
      used      <= used_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_data  <= rsp_data_nx;
      rsp_err   <= rsp_err_nx;
    end
  end

  // Storage has no reset; the sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (state == SWEEP) mem[cnt] <= '0;
    else if (wr_en)     mem[req_addr] <= req_wdata;
  end

endmodule

// File: tb/tb_heap_ram.sv
// Randomized bench for heap_ram with a behavioural heap model.
// Compares DUT outputs against the model on every falling edge.
module tb_heap_ram;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 0;
  logic          rst = 1;
  logic          req_valid = 0;
  logic          req_ready;
  logic [1:0]    req_op = 0;
  logic [AW-1:0] req_addr = 0;
  logic [DW-1:0] req_wdata = 0;
  logic [AW:0]   req_len = 0;
  logic          rsp_valid;
  logic          rsp_ready = 1;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic [AW:0]   used;
  logic          full;

  heap_ram #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .used(used), .full(full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic cmp_en = 0;

  logic [DW-1:0] m_mem [DEPTH];
  int            m_used = 0;
  logic          m_ready = 0;
  logic          m_valid = 0;
  logic [DW-1:0] m_data = 0;
  logic          m_err = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("req_ready", req_ready, m_ready);
      chk("used", used, m_used);
      chk("full", full, m_used == DEPTH);
      chk("rsp_valid", rsp_valid, m_valid);
      if (m_valid) begin
        chk("rsp_data", rsp_data, m_data);
        chk("rsp_err", rsp_err, m_err);
      end
    end
  end

  task automatic junk();
    req_valid = 1'($urandom);
    req_op    = 2'($urandom);
    req_addr  = 4'($urandom);
    req_wdata = $urandom;
    req_len   = 5'($urandom);
  endtask

  task automatic zero_mem();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
  endtask

  task automatic model_accept(input logic [1:0] op, input logic [3:0] addr,
                              input logic [31:0] wd, input logic [4:0] len);
    m_valid = 1; m_ready = 0; m_data = 0; m_err = 0;
    case (op)
      2'b00: if (int'(addr) < m_used) m_data = m_mem[addr];
             else m_err = 1;
      2'b01: if (int'(addr) < m_used) m_mem[addr] = wd;
             else m_err = 1;
      2'b10: if (len != 0 && m_used + int'(len) <= DEPTH) begin
               m_data = DW'(m_used);
               m_used = m_used + int'(len);
             end else m_err = 1;
      default: ;
    endcase
  endtask

  task automatic reset_assert();
    rst = 1;
    #1;
    m_valid = 0; m_ready = 0; m_used = 0;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_used", used, 0);
    chk("rst_full", full, 0);
  endtask

  task automatic reset_release();
    @(negedge clk);
    rst = 0;
    req_valid = 0;
    rsp_ready = 1;
    zero_mem();
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      if (i == DEPTH - 2) chk("sweep_not_ready", req_ready, 0);
    end
    m_ready = 1;
    chk("ready_after_sweep", req_ready, 1);
  endtask

  task automatic do_req(input logic [1:0] op, input logic [3:0] addr,
                        input logic [31:0] wd, input logic [4:0] len,
                        input int stall,
                        output logic [31:0] gd, output logic ge);
    req_valid = 1; req_op = op; req_addr = addr;
    req_wdata = wd; req_len = len;
    @(posedge clk); #1;
    if (op == 2'b11) begin
      m_used = 0; m_ready = 0; m_valid = 0;
      zero_mem();
      for (int i = 0; i < DEPTH; i++) begin
        @(negedge clk); junk();
        @(posedge clk); #1;
      end
      m_valid = 1; m_data = 0; m_err = 0;
    end else begin
      model_accept(op, addr, wd, len);
    end
    @(negedge clk);
    junk();
    rsp_ready = (stall == 0);
    gd = rsp_data;
    ge = rsp_err;
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      @(negedge clk); junk();
      if (k == stall - 1) rsp_ready = 1;
    end
    @(posedge clk); #1;
    m_valid = 0; m_ready = 1;
    @(negedge clk);
    req_valid = 0;
    rsp_ready = 1;
  endtask

  initial begin
    logic [31:0] gd;
    logic ge;
    int r;
    zero_mem();
    #12;
    cmp_en = 1;
    reset_release();

    do_req(2'b10, 0, 0, 5, 0, gd, ge);
    chk("alloc5_base", gd, 0);
    chk("alloc5_used", used, 5);
    do_req(2'b10, 0, 0, 3, 1, gd, ge);
    chk("alloc3_base", gd, 5);
    chk("alloc3_used", used, 8);
    do_req(2'b01, 7, 32'hDEADBEEF, 0, 0, gd, ge);
    chk("write7_err", ge, 0);
    do_req(2'b00, 7, 0, 0, 0, gd, ge);
    chk("read7_data", gd, 32'hDEADBEEF);
    chk("read7_err", ge, 0);
    do_req(2'b00, 8, 0, 0, 0, gd, ge);
    chk("read8_err", ge, 1);
    chk("read8_data", gd, 0);
    do_req(2'b10, 0, 0, 9, 0, gd, ge);
    chk("alloc9_err", ge, 1);
    chk("alloc9_used", used, 8);
    do_req(2'b10, 0, 0, 8, 0, gd, ge);
    chk("alloc8_base", gd, 8);
    chk("alloc8_used", used, 16);
    chk("alloc8_full", full, 1);
    do_req(2'b10, 0, 0, 0, 0, gd, ge);
    chk("alloc0_err", ge, 1);
    do_req(2'b00, 7, 0, 0, 5, gd, ge);
    chk("bp_read_data", gd, 32'hDEADBEEF);
    chk("bp_idle_after", req_ready, 1);
    do_req(2'b11, 0, 0, 0, 0, gd, ge);
    chk("clear_used", used, 0);
    chk("clear_err", ge, 0);
    do_req(2'b10, 0, 0, 16, 0, gd, ge);
    chk("realloc_base", gd, 0);
    do_req(2'b00, 7, 0, 0, 0, gd, ge);
    chk("read7_cleared", gd, 0);

    // Reset while a response is pending.
    do_req(2'b01, 3, 32'h1234_5678, 0, 0, gd, ge);
    req_valid = 1; req_op = 0; req_addr = 3;
    @(posedge clk); #1;
    model_accept(2'b00, 3, 0, 0);
    req_valid = 0;
    rsp_ready = 0;
    repeat (2) @(posedge clk);
    #3;
    reset_assert();
    reset_release();

    // Reset partway through a clear sweep.
    do_req(2'b10, 0, 0, 4, 0, gd, ge);
    req_valid = 1; req_op = 2'b11;
    @(posedge clk); #1;
    m_used = 0; m_ready = 0; m_valid = 0;
    req_valid = 0;
    repeat (5) @(posedge clk);
    #3;
    reset_assert();
    reset_release();

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        @(posedge clk); #3;
        reset_assert();
        reset_release();
      end else begin
        logic [1:0] op;
        if (r < 35)      op = 2'b00;
        else if (r < 65) op = 2'b01;
        else if (r < 92) op = 2'b10;
        else             op = 2'b11;
        do_req(op, 4'($urandom), $urandom,
               5'($urandom_range(0, 17)),
               $urandom_range(0, 3), gd, ge);
        repeat ($urandom_range(0, 2)) begin
          junk();
          req_valid = 0;
          @(negedge clk);
        end
      end
    end

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
